key_mode_ctrl: RTL and testbench

//  Input-side controller for the digital clock: debounces three raw push-buttons and turns them into the

---
 rtl/clock_defs_pkg.sv | 47 ++++
 rtl/key_mode_ctrl_debounce.sv | 65 ++++++
 rtl/key_mode_ctrl.sv | 154 +++++++++++++++
 tb/tb_key_mode_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_defs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : clock_defs_pkg                                               |
// | Description : Shared definitions for the digital clock: display modes,     |
// |               set-field codes, packed-BCD limits and a BCD increment       |
// |               helper. Used by key_mode_ctrl, the display mux and the       |
// |               clock-time counter.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package clock_defs_pkg;

    // Display / key mode. 2'b11 is never driven.
    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'b00,
        MODE_ALARM     = 2'b01,
        MODE_STOPWATCH = 2'b10
    } mode_e;

    // Field currently being set.
    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    // Packed-BCD upper limits.
    localparam logic [7:0] BCD_MAX_HOUR   = 8'h23;
    localparam logic [7:0] BCD_MAX_MINSEC = 8'h59;

    // Packed-BCD increment that wraps to 00 at max_value. No carry out:
    // neighbouring fields are never touched.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value,
                                           input logic [7:0] max_value);
        logic [3:0] w_hi;
        logic [3:0] w_lo;
        w_hi = value[7:4];
        w_lo = value[3:0];
        if (value == max_value) begin
            bcd_inc = 8'h00;
        end else if (w_lo == 4'd9) begin
            bcd_inc = {w_hi + 4'd1, 4'h0};
        end else begin
            bcd_inc = {w_hi, w_lo + 4'd1};
        end
    endfunction

endpackage : clock_defs_pkg
`default_nettype wire

// File: rtl/key_mode_ctrl_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_debounce                                                 |
// | Description : One push-button front end: 2-FF synchroniser, stability     |
// |               counter debounce and a registered one-cycle press pulse.     |
// | Ports       : clk, rst   - clock / async active-high reset                 |
// |               key_n      - raw active-low button, asynchronous to clk      |
// |               press      - one-cycle pulse on debounced 1->0 transition    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_armed;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // The synchroniser resets to "pressed" and the debouncer stays disarmed
    // until a released sample has been seen. A key held through reset
    // therefore never produces a press; it must be released and re-pressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_armed   <= 1'b0;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= key_n;
            r_sync2   <= r_sync1;
            r_armed   <= r_armed | r_sync2;
            r_level_d <= r_level;
            r_press   <= r_level_d & ~r_level;
            if (!r_armed || (r_sync2 == r_level)) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                // DEBOUNCE_CYCLES consecutive differing samples: accept.
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
        end
    end

    assign press = r_press;

endmodule : key_debounce
`default_nettype wire

// File: rtl/key_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_mode_ctrl                                                |
// | Description : Debounces the mode/select/increment buttons and produces the |
// |               display mode, set field, packed-BCD alarm registers and      |
// |               one-cycle command pulses for clock counter and stopwatch.    |
// | Ports       : clk, rst                  - clock / async active-high reset  |
// |               key_mode_n/sel_n/inc_n    - raw active-low buttons           |
// |               key_b                     - mode 00 clock/01 alarm/10 sw     |
// |               set_field                 - 0 none,1 hour,2 minute,3 second  |
// |               alarm_hour/minute/second  - packed-BCD alarm time            |
// |               clk_set_inc, sw_start_stop, sw_clear - one-cycle pulses      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module key_mode_ctrl
    import clock_defs_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode_n,
    input  logic       key_sel_n,
    input  logic       key_inc_n,
    output logic [1:0] key_b,
    output logic [1:0] set_field,
    output logic [7:0] alarm_hour,
    output logic [7:0] alarm_minute,
    output logic [7:0] alarm_second,
    output logic       clk_set_inc,
    output logic       sw_start_stop,
    output logic       sw_clear
);

    logic w_mode_press;
    logic w_sel_press;
    logic w_inc_press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_mode (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_mode_n),
        .press (w_mode_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_sel (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_sel_n),
        .press (w_sel_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_inc (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_inc_n),
        .press (w_inc_press)
    );

    // Same-cycle arbitration: mode beats select beats increment; losers are dropped.
    logic w_mode_ev;
    logic w_sel_ev;
    logic w_inc_ev;
    assign w_mode_ev = w_mode_press;
    assign w_sel_ev  = w_sel_press & ~w_mode_press;
    assign w_inc_ev  = w_inc_press & ~w_mode_press & ~w_sel_press;

    mode_e      r_mode,          w_mode_next;
    logic [1:0] r_set_field,     w_set_field_next;
    logic [7:0] r_alarm_hour,    w_alarm_hour_next;
    logic [7:0] r_alarm_minute,  w_alarm_minute_next;
    logic [7:0] r_alarm_second,  w_alarm_second_next;
    logic       r_clk_set_inc,   w_clk_set_inc_next;
    logic       r_sw_start_stop, w_sw_start_stop_next;
    logic       r_sw_clear,      w_sw_clear_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode          <= MODE_CLOCK;
            r_set_field     <= FIELD_NONE;
            r_alarm_hour    <= 8'h00;
            r_alarm_minute  <= 8'h00;
            r_alarm_second  <= 8'h00;
            r_clk_set_inc   <= 1'b0;
            r_sw_start_stop <= 1'b0;
            r_sw_clear      <= 1'b0;
        end else begin
            r_mode          <= w_mode_next;
            r_set_field     <= w_set_field_next;
            r_alarm_hour    <= w_alarm_hour_next;
            r_alarm_minute  <= w_alarm_minute_next;
            r_alarm_second  <= w_alarm_second_next;
            r_clk_set_inc   <= w_clk_set_inc_next;
            r_sw_start_stop <= w_sw_start_stop_next;
            r_sw_clear      <= w_sw_clear_next;
        end
    end

    always_comb begin
        w_mode_next          = r_mode;
        w_set_field_next     = r_set_field;
        w_alarm_hour_next    = r_alarm_hour;
        w_alarm_minute_next  = r_alarm_minute;
        w_alarm_second_next  = r_alarm_second;
        w_clk_set_inc_next   = 1'b0;
        w_sw_start_stop_next = 1'b0;
        w_sw_clear_next      = 1'b0;

        if (w_mode_ev) begin
            case (r_mode)
                MODE_CLOCK: w_mode_next = MODE_ALARM;
                MODE_ALARM: w_mode_next = MODE_STOPWATCH;
                default:    w_mode_next = MODE_CLOCK;
            endcase
            w_set_field_next = FIELD_NONE;
        end else if (w_sel_ev) begin
            if (r_mode == MODE_STOPWATCH) begin
                w_sw_clear_next = 1'b1;
            end else begin
                // 2-bit wrap gives none->hour->minute->second->none.
                w_set_field_next = r_set_field + 2'd1;
            end
        end else if (w_inc_ev) begin
            case (r_mode)
                MODE_CLOCK: begin
                    if (r_set_field != FIELD_NONE) begin
                        w_clk_set_inc_next = 1'b1;
                    end
                end
                MODE_ALARM: begin
                    case (r_set_field)
                        FIELD_HOUR: w_alarm_hour_next   = bcd_inc(r_alarm_hour, BCD_MAX_HOUR);
                        FIELD_MIN:  w_alarm_minute_next = bcd_inc(r_alarm_minute, BCD_MAX_MINSEC);
                        FIELD_SEC:  w_alarm_second_next = bcd_inc(r_alarm_second, BCD_MAX_MINSEC);
                        default:    ;
                    endcase
                end
                default: w_sw_start_stop_next = 1'b1;
            endcase
        end
    end

    assign key_b         = r_mode;
    assign set_field     = r_set_field;
    assign alarm_hour    = r_alarm_hour;
    assign alarm_minute  = r_alarm_minute;
    assign alarm_second  = r_alarm_second;
    assign clk_set_inc   = r_clk_set_inc;
    assign sw_start_stop = r_sw_start_stop;
    assign sw_clear      = r_sw_clear;

endmodule : key_mode_ctrl
`default_nettype wire

// File: tb/tb_key_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_key_mode_ctrl                                             |
// | Description : Directed self-checking bench for key_mode_ctrl with a short  |
// |               debounce window (DEBOUNCE_CYCLES = 4).                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_key_mode_ctrl;

    logic       clk;
    logic       rst;
    logic       key_mode_n;
    logic       key_sel_n;
    logic       key_inc_n;
    logic [1:0] key_b;
    logic [1:0] set_field;
    logic [7:0] alarm_hour;
    logic [7:0] alarm_minute;
    logic [7:0] alarm_second;
    logic       clk_set_inc;
    logic       sw_start_stop;
    logic       sw_clear;

    key_mode_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .key_mode_n    (key_mode_n),
        .key_sel_n     (key_sel_n),
        .key_inc_n     (key_inc_n),
        .key_b         (key_b),
        .set_field     (set_field),
        .alarm_hour    (alarm_hour),
        .alarm_minute  (alarm_minute),
        .alarm_second  (alarm_second),
        .clk_set_inc   (clk_set_inc),
        .sw_start_stop (sw_start_stop),
        .sw_clear      (sw_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Pulse statistics gathered over one press window.
    int n_inc, n_ss, n_clr, max_run, n_bad11;
    int run_inc, run_ss, run_clr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] t;
        t[7:4] = 4'(v / 10);
        t[3:0] = 4'(v % 10);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_inc = 0; n_ss = 0; n_clr = 0; max_run = 0;
        run_inc = 0; run_ss = 0; run_clr = 0;
    endtask

    task automatic sample();
        if (key_b == 2'b11) n_bad11++;
        if (clk_set_inc)   n_inc++;
        if (sw_start_stop) n_ss++;
        if (sw_clear)      n_clr++;
        run_inc = clk_set_inc   ? run_inc + 1 : 0;
        run_ss  = sw_start_stop ? run_ss + 1  : 0;
        run_clr = sw_clear      ? run_clr + 1 : 0;
        if (run_inc > max_run) max_run = run_inc;
        if (run_ss  > max_run) max_run = run_ss;
        if (run_clr > max_run) max_run = run_clr;
    endtask

    // mask bit 0 = mode, 1 = sel, 2 = inc. Keys low for 10 sampled edges,
    // then released and left idle long enough for the release to settle.
    task automatic press(input logic [2:0] mask);
        clear_stats();
        key_mode_n = ~mask[0];
        key_sel_n  = ~mask[1];
        key_inc_n  = ~mask[2];
        for (int i = 0; i < 22; i++) begin
            if (i == 10) begin
                key_mode_n = 1'b1;
                key_sel_n  = 1'b1;
                key_inc_n  = 1'b1;
            end
            tick();
            sample();
        end
    endtask

    int         first_change;
    logic [1:0] prev_b;

    initial begin
        n_bad11    = 0;
        rst        = 1'b1;
        key_mode_n = 1'b1;
        key_sel_n  = 1'b1;
        key_inc_n  = 1'b1;
        clear_stats();
        repeat (3) tick();

        // Reset state
        check("rst_key_b", 32'(key_b), 32'h0);
        check("rst_set_field", 32'(set_field), 32'h0);
        check("rst_alarm", {8'h0, alarm_hour, alarm_minute, alarm_second}, 32'h0);
        check("rst_pulses", {29'h0, clk_set_inc, sw_start_stop, sw_clear}, 32'h0);
        rst = 1'b0;
        repeat (5) tick();

        // 1: mode cycle
        press(3'b001);
        check("t1_alarm", {28'h0, key_b, set_field}, {28'h0, 2'b01, 2'd0});
        press(3'b001);
        check("t1_sw", {28'h0, key_b, set_field}, {28'h0, 2'b10, 2'd0});
        press(3'b001);
        check("t1_clock", {28'h0, key_b, set_field}, {28'h0, 2'b00, 2'd0});

        // 2: glitch rejection and exact latency
        press(3'b001);
        check("t2_alarm", 32'(key_b), 32'h1);
        key_mode_n = 1'b0;
        repeat (3) tick();
        key_mode_n = 1'b1;
        repeat (12) begin tick(); sample(); end
        check("t2_glitch", 32'(key_b), 32'h1);
        prev_b       = key_b;
        first_change = -1;
        key_mode_n   = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            if (i == 11) key_mode_n = 1'b1;
            tick();
            sample();
            if (first_change < 0 && key_b != prev_b) first_change = i;
        end
        check("t2_latency", 32'(first_change), 32'd8);
        check("t2_one_event", 32'(key_b), 32'h2);
        press(3'b001);
        press(3'b001);
        check("t2_back_alarm", 32'(key_b), 32'h1);

        // 3: alarm BCD increment
        press(3'b010);
        check("t3_field_hour", 32'(set_field), 32'd1);
        for (int i = 1; i <= 24; i++) begin
            press(3'b100);
            check($sformatf("t3_hour_%0d", i), 32'(alarm_hour), 32'(to_bcd(i % 24)));
        end
        press(3'b010);
        check("t3_field_min", 32'(set_field), 32'd2);
        for (int i = 1; i <= 60; i++) begin
            press(3'b100);
            check($sformatf("t3_min_%0d", i), 32'(alarm_minute), 32'(to_bcd(i % 60)));
        end
        press(3'b010);
        press(3'b100);
        check("t3_sec", {8'h0, alarm_hour, alarm_minute, alarm_second}, 32'h00_00_01);
        press(3'b010);
        check("t3_field_none", 32'(set_field), 32'd0);
        press(3'b100);
        check("t3_none_ignored", {8'h0, alarm_hour, alarm_minute, alarm_second}, 32'h00_00_01);

        // 4: clock set pulses
        press(3'b001);
        press(3'b001);
        check("t4_clock", {28'h0, key_b, set_field}, {28'h0, 2'b00, 2'd0});
        press(3'b100);
        check("t4_no_pulse", 32'(n_inc), 32'd0);
        press(3'b010);
        check("t4_field_hour", 32'(set_field), 32'd1);
        press(3'b100);
        check("t4_inc_pulse", 32'(n_inc), 32'd1);
        check("t4_inc_width", 32'(max_run), 32'd1);
        check("t4_alarm_kept", {8'h0, alarm_hour, alarm_minute, alarm_second}, 32'h00_00_01);

        // 5: stopwatch commands and same-cycle priority
        press(3'b001);
        check("t5_field_cleared", {28'h0, key_b, set_field}, {28'h0, 2'b01, 2'd0});
        press(3'b001);
        press(3'b100);
        check("t5_ss_pulse", {n_ss[15:0], n_inc[15:0]}, {16'd1, 16'd0});
        check("t5_ss_width", 32'(max_run), 32'd1);
        press(3'b010);
        check("t5_clear_pulse", 32'(n_clr), 32'd1);
        check("t5_clear_field", 32'(set_field), 32'd0);
        press(3'b101);
        check("t5_priority_mode", 32'(key_b), 32'h0);
        check("t5_priority_no_ss", 32'(n_ss), 32'd0);

        // 6: reset mid-hold of inc in ALARM
        press(3'b001);
        press(3'b010);
        press(3'b100);
        check("t6_setup", {20'h0, key_b, set_field, alarm_hour}, {20'h0, 2'b01, 2'd1, 8'h01});
        key_inc_n = 1'b0;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_state", {20'h0, key_b, set_field, alarm_hour}, 32'h0);
        check("t6_async_alarm", {8'h0, alarm_hour, alarm_minute, alarm_second}, 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        clear_stats();
        repeat (20) begin tick(); sample(); end
        check("t6_no_pulse", 32'(n_inc + n_ss + n_clr), 32'd0);
        key_inc_n = 1'b1;
        repeat (12) tick();

        // 6b: held select across reset is discarded, re-press acts
        key_sel_n = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (15) tick();
        check("t6_sel_discarded", 32'(set_field), 32'd0);
        key_sel_n = 1'b1;
        repeat (12) tick();
        press(3'b010);
        check("t6_sel_repress", 32'(set_field), 32'd1);
        press(3'b100);
        check("t6_inc_repress", 32'(n_inc), 32'd1);

        check("never_mode_11", 32'(n_bad11), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_key_mode_ctrl
`default_nettype wire
